// File: rtl/kmer_quality_window_if.sv
// ----------------------------------------------------------------------------
// kmer_quality_window_if
// Bundles the read-setup inputs, the serial base stream handshake and the
// per-window quality outputs of kmer_quality_window.
//   slave  : view taken by kmer_quality_window (consumes bases, emits windows)
//   master : view taken by the feeder / downstream pair driving the block
// Signals:
//   start, kmer_length_in, read_length, q_thresh0..2  read setup
//   base_valid, base_qual, base_ready                  base transfer handshake
//   valid, quality, kmer_length, window_index          window output
//   done, err                                          end-of-read / reject
// ----------------------------------------------------------------------------
interface kmer_quality_window_if #(
    parameter int MAX_KMER_BIT_WIDTH = 6,
    parameter int MAX_KMER_WIDTH     = (1 << MAX_KMER_BIT_WIDTH),
    parameter int PHRED_WIDTH        = 6,
    parameter int MAX_READ_BIT_WIDTH = 10
);
    logic                            start;
    logic [MAX_KMER_BIT_WIDTH-1:0]   kmer_length_in;
    logic [MAX_READ_BIT_WIDTH-1:0]   read_length;
    logic [PHRED_WIDTH-1:0]          q_thresh0;
    logic [PHRED_WIDTH-1:0]          q_thresh1;
    logic [PHRED_WIDTH-1:0]          q_thresh2;
    logic                            base_valid;
    logic [PHRED_WIDTH-1:0]          base_qual;
    logic                            base_ready;
    logic                            valid;
    logic [2*MAX_KMER_WIDTH-1:0]     quality;
    logic [MAX_KMER_BIT_WIDTH-1:0]   kmer_length;
    logic [MAX_READ_BIT_WIDTH-1:0]   window_index;
    logic                            done;
    logic                            err;

    modport slave (
        input  start, kmer_length_in, read_length,
        input  q_thresh0, q_thresh1, q_thresh2,
        input  base_valid, base_qual,
        output base_ready,
        output valid, quality, kmer_length, window_index,
        output done, err
    );

    modport master (
        output start, kmer_length_in, read_length,
        output q_thresh0, q_thresh1, q_thresh2,
        output base_valid, base_qual,
        input  base_ready,
        input  valid, quality, kmer_length, window_index,
        input  done, err
    );
endinterface

// File: rtl/kmer_quality_window.sv
// ----------------------------------------------------------------------------
// kmer_quality_window
// Accepts one read's Phred qualities serially, quantizes each base to a 2-bit
// code against three latched thresholds, keeps a sliding window of k codes and
// emits one packed quality vector per k-mer position, followed by a one-cycle
// done pulse.
// Ports:
//   clk   clock
//   rstb  synchronous active-low reset
//   bus   kmer_quality_window_if.slave (setup, base handshake, window outputs)
// ----------------------------------------------------------------------------
module kmer_quality_window #(
    parameter int MAX_KMER_BIT_WIDTH = 6,
    parameter int MAX_KMER_WIDTH     = (1 << MAX_KMER_BIT_WIDTH),
    parameter int PHRED_WIDTH        = 6,
    parameter int MAX_READ_BIT_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rstb,
    kmer_quality_window_if.slave  bus
);
    localparam int QW = 2 * MAX_KMER_WIDTH;
    localparam int KB = MAX_KMER_BIT_WIDTH;
    localparam int RB = MAX_READ_BIT_WIDTH;
    localparam int PW = PHRED_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_SLIDE,
        S_FLUSH
    } state_t;

    state_t          state_q,  state_d;
    logic [KB-1:0]   k_q,      k_d;
    logic [RB-1:0]   len_q,    len_d;
    logic [PW-1:0]   t0_q,     t0_d;
    logic [PW-1:0]   t1_q,     t1_d;
    logic [PW-1:0]   t2_q,     t2_d;
    logic [QW-1:0]   win_q,    win_d;
    logic [RB-1:0]   cnt_q,    cnt_d;
    logic            valid_q,  valid_d;
    logic            done_q,   done_d;
    logic            err_q,    err_d;
    logic [QW-1:0]   qual_q,   qual_d;
    logic [RB-1:0]   idx_q,    idx_d;

    logic            ready;
    logic            xfer;
    logic [1:0]      code;
    logic [KB:0]     ins_pos;
    logic [QW-1:0]   win_ins;
    logic [RB-1:0]   cnt_inc;
    logic [RB-1:0]   k_ext;

    assign ready   = (state_q == S_FILL) || (state_q == S_SLIDE);
    assign xfer    = bus.base_valid && ready;
    assign k_ext   = RB'(k_q);
    assign cnt_inc = cnt_q + 1'b1;

    // Quantize the incoming base against the latched thresholds.
    always_comb begin
        code = 2'd0;
        if (bus.base_qual >= t2_q) begin
            code = 2'd3;
        end else if (bus.base_qual >= t1_q) begin
            code = 2'd2;
        end else if (bus.base_qual >= t0_q) begin
            code = 2'd1;
        end
    end

    // Shift the window one slot toward slot 0 and drop the new code into
    // slot k-1. Slots at or above k start at zero and stay zero because the
    // right shift only ever moves zeros down into slot k-1 before insertion.
    assign ins_pos = {k_q - 1'b1, 1'b0};
    assign win_ins = (win_q >> 2) | ({{(QW-2){1'b0}}, code} << ins_pos);

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        len_d   = len_q;
        t0_d    = t0_q;
        t1_d    = t1_q;
        t2_d    = t2_q;
        win_d   = win_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        err_d   = err_q;
        qual_d  = qual_q;
        idx_d   = idx_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    k_d   = bus.kmer_length_in;
                    len_d = bus.read_length;
                    t0_d  = bus.q_thresh0;
                    t1_d  = bus.q_thresh1;
                    t2_d  = bus.q_thresh2;
                    win_d = '0;
                    cnt_d = '0;
                    err_d = 1'b0;
                    if ((bus.kmer_length_in == '0) ||
                        (bus.read_length < RB'(bus.kmer_length_in))) begin
                        err_d   = 1'b1;
                        state_d = S_FLUSH;
                    end else begin
                        state_d = S_FILL;
                    end
                end
            end

            S_FILL, S_SLIDE: begin
                if (xfer) begin
                    win_d = win_ins;
                    cnt_d = cnt_inc;
                    if (cnt_inc >= k_ext) begin
                        valid_d = 1'b1;
                        qual_d  = win_ins;
                        idx_d   = cnt_inc - k_ext;
                    end
                    // A read with length == k ends on its first window, so
                    // the read-end test takes priority over entering SLIDE.
                    if (cnt_inc == len_q) begin
                        state_d = S_FLUSH;
                    end else if (cnt_inc == k_ext) begin
                        state_d = S_SLIDE;
                    end
                end
            end

            S_FLUSH: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            len_q   <= '0;
            t0_q    <= '0;
            t1_q    <= '0;
            t2_q    <= '0;
            win_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            qual_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            len_q   <= len_d;
            t0_q    <= t0_d;
            t1_q    <= t1_d;
            t2_q    <= t2_d;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            err_q   <= err_d;
            qual_q  <= qual_d;
            idx_q   <= idx_d;
        end
    end

    assign bus.base_ready   = ready;
    assign bus.valid        = valid_q;
    assign bus.quality      = qual_q;
    assign bus.kmer_length  = k_q;
    assign bus.window_index = idx_q;
    assign bus.done         = done_q;
    assign bus.err          = err_q;

endmodule

// File: tb/tb_kmer_quality_window.sv
// ----------------------------------------------------------------------------
// tb_kmer_quality_window
// Directed bench for kmer_quality_window: drives reads through the interface
// and checks windows, indices, valid/done timing and error handling against
// hand-computed values.
// ----------------------------------------------------------------------------
module tb_kmer_quality_window;
    localparam int KB = 6;
    localparam int KW = 64;
    localparam int PW = 6;
    localparam int RB = 10;
    localparam int QW = 2 * KW;

    logic clk  = 1'b0;
    logic rstb = 1'b0;

    always #5 clk = ~clk;

    kmer_quality_window_if #(
        .MAX_KMER_BIT_WIDTH(KB),
        .MAX_KMER_WIDTH(KW),
        .PHRED_WIDTH(PW),
        .MAX_READ_BIT_WIDTH(RB)
    ) bus ();

    kmer_quality_window #(
        .MAX_KMER_BIT_WIDTH(KB),
        .MAX_KMER_WIDTH(KW),
        .PHRED_WIDTH(PW),
        .MAX_READ_BIT_WIDTH(RB)
    ) dut (
        .clk (clk),
        .rstb(rstb),
        .bus (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event log, sampled on the falling edge.
    logic [QW-1:0] vq[$];
    int            vidx[$];
    int            vcyc[$];
    int            dcyc[$];
    int            xcyc[$];
    int            scyc = 0;

    always @(negedge clk) begin
        if (bus.valid) begin
            vq.push_back(bus.quality);
            vidx.push_back(int'(bus.window_index));
            vcyc.push_back(cyc);
        end
        if (bus.done) dcyc.push_back(cyc);
        if (bus.base_valid && bus.base_ready) xcyc.push_back(cyc);
        if (bus.start) scyc = cyc;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [QW-1:0] obs, input logic [QW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        vq.delete();
        vidx.delete();
        vcyc.delete();
        dcyc.delete();
        xcyc.delete();
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start(input int k, input int len, input int t0, input int t1, input int t2);
        @(posedge clk);
        #1;
        bus.kmer_length_in = KB'(k);
        bus.read_length    = RB'(len);
        bus.q_thresh0      = PW'(t0);
        bus.q_thresh1      = PW'(t1);
        bus.q_thresh2      = PW'(t2);
        bus.start          = 1'b1;
        @(posedge clk);
        #1;
        bus.start          = 1'b0;
    endtask

    task automatic send(input int q, input int gap);
        int n;
        n = 0;
        bus.base_valid = 1'b1;
        bus.base_qual  = PW'(q);
        @(negedge clk);
        while (!bus.base_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: base_ready observed 0 required 1");
        end
        @(posedge clk);
        #1;
        bus.base_valid = 1'b0;
        tick(gap);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: observed timeout required finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] exp8 [3];
        int         quals6 [6];
        exp8[0] = 8'b11100100;
        exp8[1] = 8'b00111001;
        exp8[2] = 8'b11001110;
        quals6  = '{5, 15, 25, 35, 5, 35};

        bus.start          = 1'b0;
        bus.kmer_length_in = '0;
        bus.read_length    = '0;
        bus.q_thresh0      = '0;
        bus.q_thresh1      = '0;
        bus.q_thresh2      = '0;
        bus.base_valid     = 1'b0;
        bus.base_qual      = '0;

        // Reset values
        rstb = 1'b0;
        tick(3);
        check("rst_valid", QW'(bus.valid), '0);
        check("rst_done", QW'(bus.done), '0);
        check("rst_err", QW'(bus.err), '0);
        check("rst_ready", QW'(bus.base_ready), '0);
        check("rst_quality", bus.quality, '0);
        check("rst_index", QW'(bus.window_index), '0);
        check("rst_klen", QW'(bus.kmer_length), '0);
        rstb = 1'b1;
        tick(2);

        // Back-to-back read k=4 len=6
        clr();
        do_start(4, 6, 10, 20, 30);
        for (int i = 0; i < 6; i++) send(quals6[i], 0);
        tick(4);
        check("t1_nwin", QW'(vq.size()), QW'(3));
        if (vq.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("t1_q%0d", i), QW'(vq[i][7:0]), QW'(exp8[i]));
                check($sformatf("t1_idx%0d", i), QW'(vidx[i]), QW'(i));
            end
            check("t1_upper_zero", vq[2] >> 8, '0);
            check("t1_last_valid_t", QW'(vcyc[2]), QW'(xcyc[5] + 1));
        end
        check("t1_ndone", QW'(dcyc.size()), QW'(1));
        if (dcyc.size() == 1 && vcyc.size() == 3)
            check("t1_done_t", QW'(dcyc[0]), QW'(vcyc[2] + 1));
        check("t1_klen", QW'(bus.kmer_length), QW'(4));
        check("t1_err", QW'(bus.err), '0);
        check("t1_hold", QW'(bus.quality[7:0]), QW'(exp8[2]));

        // Same read with gaps between bases
        clr();
        do_start(4, 6, 10, 20, 30);
        for (int i = 0; i < 6; i++) send(quals6[i], 1);
        tick(4);
        check("t2_nwin", QW'(vq.size()), QW'(3));
        if (vq.size() == 3 && xcyc.size() == 6) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("t2_q%0d", i), vq[i], QW'(exp8[i]));
                check($sformatf("t2_idx%0d", i), QW'(vidx[i]), QW'(i));
                check($sformatf("t2_t%0d", i), QW'(vcyc[i]), QW'(xcyc[i + 3] + 1));
            end
        end
        check("t2_ndone", QW'(dcyc.size()), QW'(1));
        if (dcyc.size() == 1 && xcyc.size() == 6)
            check("t2_done_t", QW'(dcyc[0]), QW'(xcyc[5] + 2));

        // Rejected read k=5 len=3
        clr();
        do_start(5, 3, 10, 20, 30);
        tick(4);
        check("t3_err", QW'(bus.err), QW'(1));
        check("t3_nwin", QW'(vq.size()), '0);
        check("t3_ndone", QW'(dcyc.size()), QW'(1));
        if (dcyc.size() == 1)
            check("t3_done_t", QW'(dcyc[0]), QW'(scyc + 2));
        do_start(4, 6, 10, 20, 30);
        check("t3_err_clr", QW'(bus.err), '0);
        for (int i = 0; i < 6; i++) send(quals6[i], 0);
        tick(4);

        // k=63 len=63 all code 3
        clr();
        do_start(63, 63, 10, 20, 30);
        for (int i = 0; i < 63; i++) send(40, 0);
        tick(4);
        check("t4_nwin", QW'(vq.size()), QW'(1));
        if (vq.size() == 1) begin
            check("t4_idx", QW'(vidx[0]), '0);
            check("t4_q", vq[0], {2'b00, {126{1'b1}}});
        end
        check("t4_ndone", QW'(dcyc.size()), QW'(1));

        // Reset mid-SLIDE, then k=2 len=2
        do_start(4, 10, 10, 20, 30);
        for (int i = 0; i < 5; i++) send(quals6[i], 0);
        rstb = 1'b0;
        tick(2);
        clr();
        rstb = 1'b1;
        tick(5);
        check("t5_no_valid", QW'(vq.size()), '0);
        check("t5_no_done", QW'(dcyc.size()), '0);
        check("t5_idle_ready", QW'(bus.base_ready), '0);
        do_start(2, 2, 10, 20, 30);
        send(35, 0);
        send(5, 0);
        tick(4);
        check("t5_nwin", QW'(vq.size()), QW'(1));
        if (vq.size() == 1) begin
            check("t5_idx", QW'(vidx[0]), '0);
            check("t5_q", vq[0], QW'(4'b0011));
        end
        check("t5_ndone", QW'(dcyc.size()), QW'(1));

        // Start pulsed during SLIDE is ignored
        clr();
        do_start(3, 6, 10, 20, 30);
        for (int i = 0; i < 4; i++) send(quals6[i], 0);
        do_start(7, 20, 1, 2, 3);
        check("t6_klen", QW'(bus.kmer_length), QW'(3));
        send(25, 0);
        send(35, 0);
        tick(4);
        check("t6_nwin", QW'(vq.size()), QW'(4));
        if (vq.size() == 4) begin
            check("t6_idx3", QW'(vidx[3]), QW'(3));
            check("t6_q3", vq[3], QW'(6'b111011));
        end
        check("t6_ndone", QW'(dcyc.size()), QW'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
